aud_loop_engine: RTL

- Audio datapath stage directly downstream of the top-level mode FSM, which drives its 3-bit mode input.
- Deserializes I2S ADC samples from the WM8731 (codec is bus master).
- Depending on mode, it passes samples through, records a mono loop into the external SRAM, or plays that loop back, then serializes the result to the DAC.

---
 rtl/aud_pkg.sv | 28 ++
 rtl/aud_loop_engine_if.sv | 37 +++
 rtl/aud_loop_engine_i2s_deser.sv | 63 ++++++
 rtl/aud_loop_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// -----------------------------------------------------------------------------
// aud_pkg
// Shared definitions for the audio datapath: the mode encoding driven by the
// top-level mode FSM, default sample/address widths, and the SRAM write-strobe
// state type used by the loop engine.
// No ports (package).
// -----------------------------------------------------------------------------
package aud_pkg;

  localparam int AUD_DATA_W = 16;
  localparam int AUD_ADDR_W = 20;

  // Mode encoding shared with the top-level mode FSM.
  typedef enum logic [2:0] {
    MODE_I2C       = 3'd0,
    MODE_PLAY      = 3'd1,
    MODE_SET       = 3'd2,
    MODE_RECD_LOOP = 3'd3,
    MODE_PLAY_LOOP = 3'd4
  } aud_mode_e;

  // SRAM write controller: idle, or one-cycle write strobe in progress.
  typedef enum logic {
    WR_IDLE   = 1'b0,
    WR_STROBE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/aud_loop_engine_if.sv
// -----------------------------------------------------------------------------
// aud_loop_engine_if
// External SRAM bus used by the loop engine.
// Signals:
//   sram_addr   word address
//   sram_wdata  write data (top drives DQ with it while sram_we_n = 0)
//   sram_rdata  read data from DQ
//   sram_we_n   write strobe, active low
//   sram_oe_n   output enable, active low
// Modports: master (engine side), slave (SRAM / top-level pad side).
// -----------------------------------------------------------------------------
interface aud_loop_engine_if;
  import aud_pkg::*;

  logic [AUD_ADDR_W-1:0] sram_addr;
  logic [AUD_DATA_W-1:0] sram_wdata;
  logic [AUD_DATA_W-1:0] sram_rdata;
  logic                  sram_we_n;
  logic                  sram_oe_n;

  modport master (
    output sram_addr,
    output sram_wdata,
    output sram_we_n,
    output sram_oe_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr,
    input  sram_wdata,
    input  sram_we_n,
    input  sram_oe_n,
    output sram_rdata
  );

endinterface

// File: rtl/aud_loop_engine_i2s_deser.sv
// -----------------------------------------------------------------------------
// i2s_deser
// I2S receive deserializer for one channel. Detects the LRCK edge that opens
// the selected channel, skips the one-bit I2S delay slot, shifts DATA_W bits
// MSB-first and pulses o_valid for one cycle when the word is complete.
// Ports:
//   i_bclk    bit clock (rising edge)
//   i_rst_n   asynchronous active-low reset
//   i_lrck    frame clock
//   i_dat     serial data
//   o_data    last complete word (stable until the next word starts shifting)
//   o_valid   one-cycle pulse, o_data complete
// CAPTURE_LOW = 1 captures the channel that starts at LRCK falling (left);
// 0 captures the channel that starts at LRCK rising (right).
// -----------------------------------------------------------------------------
module i2s_deser
  import aud_pkg::*;
#(
  parameter int DATA_W      = AUD_DATA_W,
  parameter bit CAPTURE_LOW = 1'b1
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_lrck,
  input  logic              i_dat,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              r_lrck_q;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_sr;
  logic              r_valid;
  logic              w_start;

  // The edge itself is the delay slot; the following DATA_W edges carry data.
  assign w_start = CAPTURE_LOW ? (r_lrck_q & ~i_lrck) : (~r_lrck_q & i_lrck);

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrck_q  <= 1'b1;
      r_bit_cnt <= '0;
      r_sr      <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_lrck_q <= i_lrck;
      r_valid  <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= CNT_W'(DATA_W);
      end else if (r_bit_cnt != '0) begin
        r_sr      <= {r_sr[DATA_W-2:0], i_dat};
        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
        r_valid   <= (r_bit_cnt == CNT_W'(1));
      end
    end
  end

  assign o_data  = r_sr;
  assign o_valid = r_valid;

endmodule

// File: rtl/aud_loop_engine.sv
// -----------------------------------------------------------------------------
// aud_loop_engine
// Audio datapath stage after the mode FSM. Deserializes the left ADC channel
// from the WM8731 (codec is bus master), then, by mode, passes samples
// through (PLAY), records a mono loop into external SRAM (RECD_LOOP) or plays
// the recorded loop back (PLAY_LOOP). The selected word is serialized to the
// DAC in both channels (mono duplicate).
// Ports:
//   i_AUD_BCLK     codec bit clock; all logic rising edge except DAC out flop
//   i_rst_n        asynchronous active-low reset
//   i_mode         mode from top FSM (aud_mode_e encoding)
//   i_AUD_ADCLRCK  ADC frame clock, low = left
//   i_AUD_ADCDAT   ADC serial data
//   i_AUD_DACLRCK  DAC frame clock
//   o_AUD_DACDAT   DAC serial data (falling-edge flop)
//   io_sram        SRAM bus (aud_loop_engine_if.master)
//   o_loop_len     number of recorded samples
//   o_full         recording reached MAX_ADDR
// Build option: define AUD_MONITOR_EN to hear the live input while recording;
// without it the DAC is silent in RECD_LOOP.
// -----------------------------------------------------------------------------
module aud_loop_engine
  import aud_pkg::*;
#(
  parameter int                DATA_W   = AUD_DATA_W,
  parameter int                ADDR_W   = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic [2:0]        i_mode,
  input  logic              i_AUD_ADCLRCK,
  input  logic              i_AUD_ADCDAT,
  input  logic              i_AUD_DACLRCK,
  output logic              o_AUD_DACDAT,
  aud_loop_engine_if.master io_sram,
  output logic [ADDR_W-1:0] o_loop_len,
  output logic              o_full
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // ---------------------------------------------------------------------------
  // ADC left-channel receive
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rx_data;
  logic              w_rx_valid;

  i2s_deser #(
    .DATA_W      (DATA_W),
    .CAPTURE_LOW (1'b1)
  ) u_adc_left (
    .i_bclk  (i_AUD_BCLK),
    .i_rst_n (i_rst_n),
    .i_lrck  (i_AUD_ADCLRCK),
    .i_dat   (i_AUD_ADCDAT),
    .o_data  (w_rx_data),
    .o_valid (w_rx_valid)
  );

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]        r_mode_q;
  logic [DATA_W-1:0] r_last_rx;
  wr_state_e         r_wr_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic [ADDR_W-1:0] r_loop_len;
  logic              r_full;

  wr_state_e         w_wr_state_next;
  logic [ADDR_W-1:0] w_wr_addr_next;
  logic [ADDR_W-1:0] w_rd_addr_next;
  logic [DATA_W-1:0] w_rd_data_next;
  logic [ADDR_W-1:0] w_sram_addr_next;
  logic [DATA_W-1:0] w_sram_wdata_next;
  logic [ADDR_W-1:0] w_loop_len_next;
  logic              w_full_next;
  logic [ADDR_W-1:0] w_rd_inc;

  // TX side
  logic              r_dac_lrck_q;
  logic [DATA_W-1:0] r_tx_word;
  logic [DATA_W-1:0] r_tx_sr;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic              r_dacdat;
  logic              w_dac_t1;
  logic              w_dac_tr;
  logic [DATA_W-1:0] w_out_sample;

  // ---------------------------------------------------------------------------
  // Mode transitions (seen combinationally so they act on the changing edge)
  // ---------------------------------------------------------------------------
  logic w_in_rec, w_was_rec, w_enter_rec, w_leave_rec;
  logic w_in_play, w_enter_play;

  assign w_in_rec     = (i_mode == MODE_RECD_LOOP);
  assign w_was_rec    = (r_mode_q == MODE_RECD_LOOP);
  assign w_enter_rec  = w_in_rec & ~w_was_rec;
  assign w_leave_rec  = w_was_rec & ~w_in_rec;
  assign w_in_play    = (i_mode == MODE_PLAY_LOOP);
  assign w_enter_play = w_in_play & (r_mode_q != MODE_PLAY_LOOP);

  assign w_dac_t1 = r_dac_lrck_q & ~i_AUD_DACLRCK;
  assign w_dac_tr = ~r_dac_lrck_q & i_AUD_DACLRCK;

  // ---------------------------------------------------------------------------
  // Record / play-loop control: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr_state_next   = r_wr_state;
    w_wr_addr_next    = r_wr_addr;
    w_rd_addr_next    = r_rd_addr;
    w_rd_data_next    = r_rd_data;
    w_sram_addr_next  = r_sram_addr;
    w_sram_wdata_next = r_sram_wdata;
    w_loop_len_next   = r_loop_len;
    w_full_next       = r_full;
    w_rd_inc          = (w_enter_play ? '0 : r_rd_addr) + ADDR_W'(1);

    // A strobe always retires after one cycle, even if the mode just changed,
    // so an in-flight write is counted in the address.
    if (r_wr_state == WR_STROBE) begin
      w_wr_state_next = WR_IDLE;
      w_wr_addr_next  = r_wr_addr + ADDR_W'(1);
    end

    if (w_leave_rec) begin
      w_loop_len_next = w_wr_addr_next;
    end

    // Mode change beats rx_valid: only steady RECD_LOOP issues writes.
    if (w_enter_rec) begin
      w_wr_addr_next = '0;
      w_full_next    = 1'b0;
    end else if (w_in_rec && w_was_rec && (r_wr_state == WR_IDLE) && w_rx_valid) begin
      if (r_wr_addr < MAX_ADDR) begin
        w_wr_state_next   = WR_STROBE;
        w_sram_addr_next  = r_wr_addr;
        w_sram_wdata_next = w_rx_data;
      end else begin
        w_full_next = 1'b1;
      end
    end

    if (w_enter_play) begin
      w_rd_addr_next   = '0;
      w_sram_addr_next = '0;
      w_rd_data_next   = '0;
    end

    // Sample at T1; the address then advances and is held for a whole frame
    // before the next sample. Length comes from the next-value so a T1 on the
    // same edge as RECD_LOOP -> PLAY_LOOP sees the freshly latched length.
    if (w_in_play && w_dac_t1) begin
      if (w_loop_len_next == '0) begin
        w_rd_data_next   = '0;
        w_rd_addr_next   = '0;
        w_sram_addr_next = '0;
      end else begin
        w_rd_data_next   = io_sram.sram_rdata;
        w_rd_addr_next   = (w_rd_inc == w_loop_len_next) ? '0 : w_rd_inc;
        w_sram_addr_next = w_rd_addr_next;
      end
    end
  end

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode_q     <= MODE_I2C;
      r_last_rx    <= '0;
      r_wr_state   <= WR_IDLE;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_rd_data    <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_loop_len   <= '0;
      r_full       <= 1'b0;
    end else begin
      r_mode_q     <= i_mode;
      if (w_rx_valid) begin
        r_last_rx <= w_rx_data;
      end
      r_wr_state   <= w_wr_state_next;
      r_wr_addr    <= w_wr_addr_next;
      r_rd_addr    <= w_rd_addr_next;
      r_rd_data    <= w_rd_data_next;
      r_sram_addr  <= w_sram_addr_next;
      r_sram_wdata <= w_sram_wdata_next;
      r_loop_len   <= w_loop_len_next;
      r_full       <= w_full_next;
    end
  end

  // On the PLAY_LOOP entry cycle the address is forced to 0 right away so a
  // coinciding T1 reads word 0; never while a write strobe is on the bus.
  assign io_sram.sram_addr  = (w_enter_play && (r_wr_state == WR_IDLE)) ? '0 : r_sram_addr;
  assign io_sram.sram_wdata = r_sram_wdata;
  assign io_sram.sram_we_n  = (r_wr_state != WR_STROBE);
  assign io_sram.sram_oe_n  = (r_wr_state == WR_STROBE);
  assign o_loop_len         = r_loop_len;
  assign o_full             = r_full;

  // ---------------------------------------------------------------------------
  // Output sample selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_out_sample = '0;
    case (i_mode)
      MODE_PLAY:      w_out_sample = r_last_rx;
      MODE_PLAY_LOOP: w_out_sample = r_rd_data;
`ifdef AUD_MONITOR_EN
      MODE_RECD_LOOP: w_out_sample = r_last_rx;
`else
      MODE_RECD_LOOP: w_out_sample = '0;
`endif
      default:        w_out_sample = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // DAC transmit. The word captured at T1 is replayed at the right-channel
  // edge, so both channels carry the same sample.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dac_lrck_q <= 1'b1;
      r_tx_word    <= '0;
      r_tx_sr      <= '0;
      r_tx_cnt     <= '0;
    end else begin
      r_dac_lrck_q <= i_AUD_DACLRCK;
      if (w_dac_t1) begin
        r_tx_word <= w_out_sample;
        r_tx_sr   <= w_out_sample;
        r_tx_cnt  <= CNT_W'(DATA_W);
      end else if (w_dac_tr) begin
        r_tx_sr  <= r_tx_word;
        r_tx_cnt <= CNT_W'(DATA_W);
      end else if (r_tx_cnt != '0) begin
        r_tx_sr  <= {r_tx_sr[DATA_W-2:0], 1'b0};
        r_tx_cnt <= r_tx_cnt - CNT_W'(1);
      end
    end
  end

  // Falling-edge launch gives the codec a full half-period of setup before
  // its rising-edge capture; silent once the DATA_W bits have gone out.
  always_ff @(negedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dacdat <= 1'b0;
    end else begin
      r_dacdat <= (r_tx_cnt != '0) ? r_tx_sr[DATA_W-1] : 1'b0;
    end
  end

  assign o_AUD_DACDAT = r_dacdat;

endmodule
